// File: rtl/led_seq_pkg.sv
// led_seq_pkg
// Shared definitions for the LED sequencer: the pattern-mode encoding and the
// per-bit pattern decode used to build the LED vector from the position.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_BAR    = 2'd3
  } led_mode_t;

  // Widest position value the decode accepts (NUM_LEDS up to 32 needs 6 bits).
  localparam int POS_MAX_W = 6;

  // Value of LED bit idx for a given position and mode. Rotate and bounce
  // modes light a single LED at pos; bar lights every LED below pos, so
  // pos == 0 is all-off and pos == N is all-on.
  function automatic logic led_bit(input int idx,
                                   input logic [POS_MAX_W-1:0] pos,
                                   input led_mode_t mode);
    logic lit;
    if (mode == MODE_BAR) lit = (idx < int'(pos));
    else                  lit = (idx == int'(pos));
    return lit;
  endfunction

endpackage

// File: rtl/led_pwm.sv
// led_pwm
// Free-running brightness counter with compare. gate is high while the
// counter is below brightness; an all-ones brightness forces gate high so
// full brightness is truly continuous rather than 15/16.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   brightness   on-time compare value
//   gate         combinational enable for the LED outputs
module led_pwm #(
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic                 gate
);

  logic [PWM_WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_q + 1'b1;
  end

  assign gate = (&brightness) | (count_q < brightness);

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer
// Parametrised LED pattern generator: rotate left/right, bounce and bar fill,
// advanced once every period+1 cycles while enable is high, with PWM dimming.
// Ports:
//   clk, rst_n   clock and async active-low reset
//   enable       advance the pattern while high (PWM keeps running when low)
//   mode         pattern select, see led_mode_t
//   period       step interval minus one, in clk cycles
//   brightness   PWM on-time compare value
//   leds         registered, PWM-gated pattern
//   step         one-cycle pulse when the pattern advances
//   cycle_done   one-cycle pulse with step when the pattern returns to start
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS  = 4,
  parameter int DIV_WIDTH = 24,
  parameter int PWM_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [1:0]           mode,
  input  logic [DIV_WIDTH-1:0] period,
  input  logic [PWM_WIDTH-1:0] brightness,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 step,
  output logic                 cycle_done
);

  localparam int POS_W = $clog2(NUM_LEDS + 1);
  localparam logic [POS_W-1:0] POS_ZERO = '0;
  localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PREV = POS_W'(NUM_LEDS - 2);
  localparam logic [POS_W-1:0] POS_FULL = POS_W'(NUM_LEDS);

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 dir_q, dir_d;
  led_mode_t            mode_q, mode_d, mode_in;
  logic                 step_d, done_d;
  logic [NUM_LEDS-1:0]  leds_d;
  logic                 gate;

  led_pwm #(.PWM_WIDTH(PWM_WIDTH)) u_pwm (
    .clk        (clk),
    .rst_n      (rst_n),
    .brightness (brightness),
    .gate       (gate)
  );

  assign mode_in = led_mode_t'(mode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q      <= '0;
      pos_q      <= '0;
      dir_q      <= 1'b0;
      mode_q     <= MODE_ROT_L;
      step       <= 1'b0;
      cycle_done <= 1'b0;
      leds       <= '0;
    end else begin
      div_q      <= div_d;
      pos_q      <= pos_d;
      dir_q      <= dir_d;
      mode_q     <= mode_d;
      step       <= step_d;
      cycle_done <= done_d;
      leds       <= leds_d;
    end
  end

  always_comb begin
    div_d  = div_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    mode_d = mode_q;
    step_d = 1'b0;
    done_d = 1'b0;

    if (mode_in != mode_q) begin
      // Restart from the new mode's initial state, even while disabled.
      mode_d = mode_in;
      pos_d  = POS_ZERO;
      dir_d  = 1'b0;
      div_d  = '0;
    end else if (enable) begin
      if (div_q == period) begin
        div_d  = '0;
        step_d = 1'b1;
        case (mode_q)
          MODE_ROT_L: pos_d = (pos_q == POS_LAST) ? POS_ZERO : pos_q + POS_ONE;
          MODE_ROT_R: pos_d = (pos_q == POS_ZERO) ? POS_LAST : pos_q - POS_ONE;
          MODE_BOUNCE: begin
            if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                dir_d = 1'b1;
                pos_d = POS_PREV;
              end else begin
                pos_d = pos_q + POS_ONE;
              end
            end else begin
              if (pos_q == POS_ZERO) begin
                dir_d = 1'b0;
                pos_d = POS_ONE;
              end else begin
                pos_d = pos_q - POS_ONE;
              end
            end
          end
          default: pos_d = (pos_q == POS_FULL) ? POS_ZERO : pos_q + POS_ONE;
        endcase
        // Every mode starts at pos 0. Bounce arrives at pos 0 still moving
        // down; the displayed pattern is back at start, so that counts.
        done_d = (pos_d == POS_ZERO);
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_comb begin
    leds_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      leds_d[i] = led_bit(i, POS_MAX_W'(pos_q), mode_q) & gate;
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
module tb_led_sequencer;
  localparam int DW = 24;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] period = 24'd3;
  logic [PW-1:0] brightness = 4'd15;

  logic [3:0] leds4;
  logic       step4, done4;
  logic [1:0] leds2;
  logic       step2, done2;

  always #5 clk = ~clk;

  led_sequencer #(.NUM_LEDS(4), .DIV_WIDTH(DW), .PWM_WIDTH(PW)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
    .brightness(brightness), .leds(leds4), .step(step4), .cycle_done(done4)
  );

  led_sequencer #(.NUM_LEDS(2), .DIV_WIDTH(DW), .PWM_WIDTH(PW)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .period(period),
    .brightness(brightness), .leds(leds2), .step(step2), .cycle_done(done2)
  );

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, expv);
  endtask

  // Reference model: the pattern is a function of how many steps have been
  // taken since the mode (re)started, not of any position/direction register.
  function automatic int pat(input int n, input int md, input int k);
    int m, p;
    case (md)
      0: p = k % n;
      1: p = (n - (k % n)) % n;
      2: begin
        m = k % (2 * (n - 1));
        p = (m < n) ? m : 2 * (n - 1) - m;
      end
      default: return (1 << (k % (n + 1))) - 1;
    endcase
    return 1 << p;
  endfunction

  function automatic int cyc_len(input int n, input int md);
    case (md)
      0, 1:    return n;
      2:       return 2 * (n - 1);
      default: return n + 1;
    endcase
  endfunction

  int m_mode, m_k, m_since, m_pwm;
  int e_leds4, e_leds2, e_step, e_done4, e_done2;

  always @(posedge clk or negedge rst_n) begin
    bit g;
    if (!rst_n) begin
      m_mode = 0; m_k = 0; m_since = 0; m_pwm = 0;
      e_leds4 = 0; e_leds2 = 0; e_step = 0; e_done4 = 0; e_done2 = 0;
    end else begin
      g = (brightness == 15) || (m_pwm < int'(brightness));
      e_leds4 = g ? pat(4, m_mode, m_k) : 0;
      e_leds2 = g ? pat(2, m_mode, m_k) : 0;
      m_pwm = (m_pwm + 1) % 16;
      e_step = 0; e_done4 = 0; e_done2 = 0;
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_k = 0; m_since = 0;
      end else if (enable) begin
        if (m_since == int'(period)) begin
          m_since = 0;
          m_k++;
          e_step = 1;
          e_done4 = (m_k % cyc_len(4, m_mode) == 0);
          e_done2 = (m_k % cyc_len(2, m_mode) == 0);
        end else begin
          m_since++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model leds4", int'(leds4), e_leds4);
      check("model step4", int'(step4), e_step);
      check("model done4", int'(done4), e_done4);
      check("model leds2", int'(leds2), e_leds2);
      check("model step2", int'(step2), e_step);
      check("model done2", int'(done2), e_done2);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset(input int md);
    rst_n = 1'b0;
    mode = 2'(md);
    tick(2);
    rst_n = 1'b1;
  endtask

  // Returns how many cycles it took for step to appear (0 if it never did).
  task automatic wait_step(output int waited);
    waited = 0;
    for (int i = 1; i <= 60; i++) begin
      tick(1);
      if (step4) begin
        waited = i;
        return;
      end
    end
  endtask

  int exp4[8];
  int exp2[8];

  task automatic run_pattern(input string nm, input int md, input int nsteps,
                             input int done_at, input bit use2);
    int w;
    do_reset(md);
    enable = 1'b1;
    period = 24'd3;
    brightness = 4'd15;
    tick(2);
    check({nm, " init"}, int'(leds4), exp4[0]);
    if (use2) check({nm, " init n2"}, int'(leds2), exp2[0]);
    for (int j = 1; j <= nsteps; j++) begin
      wait_step(w);
      check({nm, " step seen"}, int'(w != 0), 1);
      if (w == 0) return;
      // One cycle of the 4-cycle interval is spent reading leds after a step.
      if (j > 1) check({nm, " step interval"}, w, 3);
      check({nm, " done"}, int'(done4), int'(j == done_at));
      if (use2 && j <= 2) check({nm, " done n2"}, int'(done2), int'(j == 2));
      tick(1);
      check({nm, " leds"}, int'(leds4), exp4[j]);
      if (use2 && j <= 2) check({nm, " leds n2"}, int'(leds2), exp2[j]);
    end
  endtask

  int w, cnt;

  initial begin
    tick(2);
    chk_on = 1'b1;

    exp4 = '{1, 2, 4, 8, 1, 0, 0, 0};
    run_pattern("rotl", 0, 4, 4, 1'b0);
    exp4 = '{1, 8, 4, 2, 1, 0, 0, 0};
    run_pattern("rotr", 1, 4, 4, 1'b0);
    exp4 = '{1, 2, 4, 8, 4, 2, 1, 0};
    exp2 = '{1, 2, 1, 0, 0, 0, 0, 0};
    run_pattern("bounce", 2, 6, 6, 1'b1);
    exp4 = '{0, 1, 3, 7, 15, 0, 0, 0};
    run_pattern("bar", 3, 5, 5, 1'b0);

    // Hold: freeze with div at 3, period 7. The remaining count is four
    // increments (3->7) plus the stepping edge, so step shows 5 cycles later.
    do_reset(0);
    enable = 1'b1;
    period = 24'd7;
    brightness = 4'd15;
    wait_step(w);
    check("hold first step", int'(w != 0), 1);
    tick(3);
    enable = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (step4) cnt++;
    end
    check("hold no step", cnt, 0);
    enable = 1'b1;
    wait_step(w);
    check("hold resume", w, 5);

    // Mode change with div at 5: the change edge resets div, then eight more
    // edges reach the next step.
    tick(5);
    check("pre-change leds", int'(leds4), 4);
    mode = 2'd1;
    tick(1);
    check("change no step", int'(step4), 0);
    tick(1);
    check("change leds init", int'(leds4), 1);
    wait_step(w);
    check("change next step", w + 2, 9);

    // PWM duty over one full 16-cycle counter period with the pattern held.
    do_reset(0);
    enable = 1'b0;
    period = 24'd3;
    brightness = 4'd4;
    tick(3);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(1); if (leds4 != 0) cnt++; end
    check("pwm duty 4", cnt, 4);
    brightness = 4'd0;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(1); if (leds4 != 0) cnt++; end
    check("pwm duty 0", cnt, 0);
    brightness = 4'd15;
    tick(2);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin tick(1); if (leds4 != 0) cnt++; end
    check("pwm duty 15", cnt, 16);

    // Async reset between clock edges while step and leds are high.
    enable = 1'b1;
    wait_step(w);
    check("rst pre step", int'(step4), 1);
    check("rst pre leds", int'(leds4), 1);
    #1 rst_n = 1'b0;
    #1;
    check("rst leds", int'(leds4), 0);
    check("rst step", int'(step4), 0);
    check("rst done", int'(done4), 0);
    tick(1);
    rst_n = 1'b1;
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
